// File: rtl/alu_seq_if.sv
// Handshake and data bus for the sequential ALU.
// master: issues operations and consumes results; slave: the ALU itself.
interface alu_seq_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_control;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         out_err;
  logic [3:0]   alu_flags;

  modport master (
    output in_valid, alu_control, a, b, out_ready,
    input  in_ready, out_valid, result, out_err, alu_flags
  );

  modport slave (
    input  in_valid, alu_control, a, b, out_ready,
    output in_ready, out_valid, result, out_err, alu_flags
  );
endinterface

// File: rtl/alu_seq.sv
// Parametrised N-bit sequential ALU with persistent {V,N,Z,C} flag register.
// Shifts/rotates iterate one bit per cycle. Optional iterative unsigned
// multiply on opcode 1110 when ALU_MUL_EN is defined; otherwise 1110 is reserved.
module alu_seq #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N),
  localparam int CW = SW + 1
) (
  input  logic      clk,
  input  logic      reset_n,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADC  = 4'b0010;
  localparam logic [3:0] OP_SBC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_PASS = 4'b1101;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1110;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t         state;
  logic [N-1:0]   result_q;
  logic [3:0]     flags_q;
  logic           err_q;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   sh_val;
  logic [1:0]     sh_op;
  logic           sh_c;

  logic           accept;
  logic [3:0]     op;
  logic [SW-1:0]  shamt;
  logic [N-1:0]   y;
  logic           cin;
  logic [N:0]     sum;
  logic           v_arith;
  logic [N-1:0]   ires;
  logic [3:0]     iflags;
  logic           ierr;
  logic           upd_nz;
  logic           go_shift;
  logic [N-1:0]   sh_nxt;
  logic           sh_cn;

`ifdef ALU_MUL_EN
  logic [2*N-1:0] mul_acc;
  logic [2*N-1:0] mul_mcand;
  logic [N-1:0]   mul_mplier;
  logic [2*N-1:0] mul_acc_nxt;
  logic           mul_hi;
  logic           go_mul;
`endif

  assign bus.in_ready  = reset_n & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.out_err   = err_q;
  assign bus.alu_flags = flags_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // Single-cycle datapath: result/flags for ops that complete on the accepting edge.
  always_comb begin
    op       = bus.alu_control;
    shamt    = bus.b[SW-1:0];
    y        = bus.b;
    cin      = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin y = ~bus.b; cin = 1'b1;       end
      OP_ADC:         begin             cin = flags_q[0]; end
      OP_SBC:         begin y = ~bus.b; cin = flags_q[0]; end
      default:        ;
    endcase
    sum     = {1'b0, bus.a} + {1'b0, y} + {{N{1'b0}}, cin};
    v_arith = (bus.a[N-1] == y[N-1]) & (sum[N-1] != bus.a[N-1]);

    ires     = result_q;
    iflags   = flags_q;
    ierr     = 1'b0;
    upd_nz   = 1'b0;
    go_shift = 1'b0;
`ifdef ALU_MUL_EN
    go_mul   = 1'b0;
`endif
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        ires   = sum[N-1:0];
        iflags = {v_arith, sum[N-1], sum[N-1:0] == '0, sum[N]};
      end
      OP_CMP:  iflags = {v_arith, sum[N-1], sum[N-1:0] == '0, sum[N]};
      OP_AND:  begin ires = bus.a & bus.b; upd_nz = 1'b1; end
      OP_OR:   begin ires = bus.a | bus.b; upd_nz = 1'b1; end
      OP_XOR:  begin ires = bus.a ^ bus.b; upd_nz = 1'b1; end
      OP_NOT:  begin ires = ~bus.a;        upd_nz = 1'b1; end
      OP_PASS: begin ires = bus.b;         upd_nz = 1'b1; end
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        if (shamt == '0) begin
          ires   = bus.a;
          upd_nz = 1'b1;
        end else begin
          go_shift = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      OP_MUL:  go_mul = 1'b1;
`endif
      default: begin ires = '0; ierr = 1'b1; end
    endcase
    if (upd_nz) iflags[2:1] = {ires[N-1], ires == '0};
  end

  // One-bit shift step; sh_op is the low two opcode bits (LSL/LSR/ASR/ROR).
  always_comb begin
    sh_nxt = sh_val;
    sh_cn  = sh_c;
    case (sh_op)
      2'b00: begin sh_nxt = {sh_val[N-2:0], 1'b0};      sh_cn = sh_val[N-1]; end
      2'b01: begin sh_nxt = {1'b0, sh_val[N-1:1]};      sh_cn = sh_val[0];   end
      2'b10: begin sh_nxt = {sh_val[N-1], sh_val[N-1:1]}; sh_cn = sh_val[0]; end
      default: begin sh_nxt = {sh_val[0], sh_val[N-1:1]}; sh_cn = sh_val[0]; end
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    mul_hi      = |mul_acc_nxt[2*N-1:N];
  end
`endif

  // Control FSM with registered result, error and flag outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      cnt      <= '0;
      sh_val   <= '0;
      sh_op    <= '0;
      sh_c     <= 1'b0;
`ifdef ALU_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (go_shift) begin
              state  <= SHIFT;
              sh_val <= bus.a;
              sh_op  <= op[1:0];
              sh_c   <= flags_q[0];
              cnt    <= {1'b0, shamt};
`ifdef ALU_MUL_EN
            end else if (go_mul) begin
              state      <= MUL;
              mul_acc    <= '0;
              mul_mcand  <= {{N{1'b0}}, bus.a};
              mul_mplier <= bus.b;
              cnt        <= CW'(N);
`endif
            end else begin
              state    <= DONE;
              result_q <= ires;
              flags_q  <= iflags;
              err_q    <= ierr;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sh_val <= sh_nxt;
          sh_c   <= sh_cn;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            result_q <= sh_nxt;
            flags_q  <= {flags_q[3], sh_nxt[N-1], sh_nxt == '0, sh_cn};
            err_q    <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          mul_acc    <= mul_acc_nxt;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          cnt        <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            result_q <= mul_acc_nxt[N-1:0];
            flags_q  <= {mul_hi, mul_acc_nxt[N-1], mul_acc_nxt[N-1:0] == '0, mul_hi};
            err_q    <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed + random bench for alu_seq: expected results come from a
// behavioural model and are queued at issue, then popped at out_valid.
module tb_alu_seq;
  localparam int N = 8;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, ADC = 4'h2, SBC = 4'h3;
  localparam logic [3:0] AND_ = 4'h4, OR_ = 4'h5, XOR_ = 4'h6, NOT_ = 4'h7;
  localparam logic [3:0] LSL = 4'h8, LSR = 4'h9, ASR = 4'hA, ROR = 4'hB;
  localparam logic [3:0] CMP = 4'hC, PASS = 4'hD, OPE = 4'hE, OPF = 4'hF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alu_seq_if #(.N(N)) bus ();
  alu_seq #(.N(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   fl;
    logic         err;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [3:0]   m_flags = '0;
  logic [N-1:0] m_res = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural reference: integer arithmetic and SV shift operators.
  task automatic push_exp(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic [N-1:0] r, d, av;
    logic [3:0] f;
    logic c, v;
    logic [2*N-1:0] prod;
    int ua, ub, uy, ci, full, sa, sy, s, sh;
    r = m_res; f = m_flags; av = a;
    e.err = 1'b0; e.lat = 1;
    sh = int'(b) % N;
    ua = int'(a); ub = int'(b);
    case (op)
      ADD, SUB, ADC, SBC, CMP: begin
        uy = (op == SUB || op == SBC || op == CMP) ? (2**N - 1 - ub) : ub;
        ci = (op == SUB || op == CMP) ? 1 : ((op == ADC || op == SBC) ? int'(m_flags[0]) : 0);
        full = ua + uy + ci;
        c = (full >= 2**N);
        d = N'(full);
        sa = (ua >= 2**(N-1)) ? ua - 2**N : ua;
        sy = (uy >= 2**(N-1)) ? uy - 2**N : uy;
        s = sa + sy + ci;
        v = (s > 2**(N-1) - 1) || (s < -(2**(N-1)));
        if (op != CMP) r = d;
        f = {v, d[N-1], d == '0, c};
      end
      AND_, OR_, XOR_, NOT_, PASS: begin
        case (op)
          AND_:    r = a & b;
          OR_:     r = a | b;
          XOR_:    r = a ^ b;
          NOT_:    r = ~a;
          default: r = b;
        endcase
        f = {m_flags[3], r[N-1], r == '0, m_flags[0]};
      end
      LSL, LSR, ASR, ROR: begin
        c = m_flags[0];
        if (sh == 0) r = a;
        else begin
          e.lat = sh + 1;
          case (op)
            LSL:     begin r = a << sh; c = av[N-sh]; end
            LSR:     begin r = a >> sh; c = av[sh-1]; end
            ASR:     begin r = N'($signed(a) >>> sh); c = av[sh-1]; end
            default: begin r = (a >> sh) | (a << (N - sh)); c = av[sh-1]; end
          endcase
        end
        f = {m_flags[3], r[N-1], r == '0, c};
      end
`ifdef ALU_MUL_EN
      OPE: begin
        prod = (2*N)'(a) * (2*N)'(b);
        r = prod[N-1:0];
        v = |prod[2*N-1:N];
        f = {v, r[N-1], r == '0, v};
        e.lat = N + 1;
      end
`endif
      default: begin r = '0; e.err = 1'b1; end
    endcase
    m_flags = f; m_res = r;
    e.res = r; e.fl = f;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    w = 0;
    push_exp(op, a, b);
    bus.alu_control = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && w < 64) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 64) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int lat;
    exp_t e;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      chk({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"},   32'(lat),           32'(e.lat));
    chk({tag, "_res"},   32'(bus.result),    32'(e.res));
    chk({tag, "_flags"}, 32'(bus.alu_flags), 32'(e.fl));
    chk({tag, "_err"},   32'(bus.out_err),   32'(e.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.alu_control = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'd0);
    chk("rst_res",   32'(bus.result),    32'd0);
    chk("rst_flags", 32'(bus.alu_flags), 32'd0);
    chk("rst_err",   32'(bus.out_err),   32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(bus.in_ready), 32'd1);

    send(ADD, 8'h7F, 8'h01); collect("add_ovf");
    send(SUB, 8'h05, 8'h05); collect("sub_zero");
    send(ADC, 8'h10, 8'h20); collect("adc_c");
    send(LSL, 8'h81, 8'h0B); collect("lsl3");
    send(ROR, 8'h01, 8'h01); collect("ror1");
    send(ASR, 8'h80, 8'h02); collect("asr2");
    send(LSR, 8'hA5, 8'h07); collect("lsr7");
    send(LSL, 8'hFF, 8'h07); collect("lsl7");
    send(CMP, 8'h10, 8'h20); collect("cmp");
    send(SBC, 8'h30, 8'h10); collect("sbc");
    send(AND_, 8'hF0, 8'h3C); collect("and");
    send(OR_, 8'h00, 8'h00); collect("or_zero");
    send(NOT_, 8'h0F, 8'h00); collect("not");
    send(PASS, 8'h00, 8'h9A); collect("pass");

    // Back-pressure: DONE holds with out_ready low, then a new op is taken on release.
    send(ADD, 8'h01, 8'h01);
    bus.out_ready = 1'b0;
    collect("hold_add");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_res",   32'(bus.result),    32'h02);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
    end
    push_exp(XOR_, 8'hFF, 8'h0F);
    bus.alu_control = XOR_; bus.a = 8'hFF; bus.b = 8'h0F; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    collect("xor_b2b");

    send(OPF, 8'h12, 8'h34); collect("rsv_f");
    send(SUB, 8'h05, 8'h05); collect("sub_setc");
    send(LSL, 8'h5A, 8'h00); collect("lsl0");
    send(OPE, 8'h10, 8'h10); collect("op_e");
    send(OPE, 8'h0F, 8'h03); collect("op_e2");

    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)), N'($urandom), N'($urandom));
      collect("rand");
    end

    // Asynchronous reset in the middle of a long shift.
    send(ROR, 8'h01, 8'h01); collect("ror_pre");
    send(LSL, 8'h33, 8'h07);
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_flags", 32'(bus.alu_flags), 32'd0);
    chk("mid_rst_res",   32'(bus.result),    32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready),  32'd0);
    void'(sb.pop_front());
    m_flags = '0; m_res = '0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    send(ADD, 8'h22, 8'h11); collect("post_rst_add");

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised N-bit sequential ALU that replaces the 4-bit combinational ALU in the processing unit datapath.
- Accepts one operation per valid/ready handshake and returns a registered result plus a persistent {V,N,Z,C} flag register.
- Carry-chained ops (ADC/SBC) read the flag register.
- Shifts and rotates run iteratively, one bit per cycle.

Parameters:
- N, 8, operand/result width (N >= 4, power of 2).
- SW, $clog2(N), shift-amount width taken from b[SW-1:0]; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation.
- alu_control  in  4  opcode.
- a  in  N  operand A.
- b  in  N  operand B; low SW bits are the shift amount for shift ops.
- out_valid  out  1  result/flags available.
- out_ready  in  1  consumer accepts result.
- result  out  N  registered result.
- out_err  out  1  reserved opcode; qualified by out_valid.
- alu_flags  out  4  registered {V,N,Z,C}.

Behaviour:
- Opcodes:
  - 0000 ADD a+b; 0001 SUB a+~b+1; 0010 ADC a+b+C; 0011 SBC a+~b+C.
  - 0100 AND; 0101 OR; 0110 XOR; 0111 NOT a.
  - 1000 LSL; 1001 LSR; 1010 ASR; 1011 ROR, each by shamt=b[SW-1:0].
  - 1100 CMP (flags as SUB, result unchanged); 1101 PASS b; 1110/1111 reserved.
- Arithmetic is done as an (N+1)-bit sum {Cout,sum}.
  - C = Cout (SUB/SBC: C=1 means no borrow).
  - V = (a[N-1] == y[N-1]) & (sum[N-1] != a[N-1]), where y is the second operand after inversion.
- Flags for every non-reserved op:
  - N = result[N-1] (for CMP, the difference MSB).
  - Z = (value == 0).
- Logic ops and PASS: C and V keep their previous values.
- Shifts: C = last bit shifted out; V unchanged. shamt=0 leaves the operand unchanged and C unchanged.
- Reserved opcode: result=0, out_err=1, flags unchanged.
- FSM states IDLE, SHIFT, DONE:
  - IDLE --(in_valid & non-shift, or shift with shamt=0)--> DONE. The result and flags are computed from the inputs and registered on the accepting edge.
  - IDLE --(in_valid & shift, shamt>0)--> SHIFT. Operand and cnt=shamt are loaded.
  - SHIFT: each edge shifts one bit, updates shadow C and decrements cnt. When cnt reaches 1→0: go to DONE, commit result and flags.
  - DONE: out_valid=1. out_ready=0 holds result/out_err/out_valid/alu_flags stable. out_ready=1 leaves DONE: to IDLE, or directly accepts a new op if in_valid=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready); forced 0 while reset_n=0.
- Latency, accept edge to out_valid:
  - 1 cycle for non-shift ops and shamt=0.
  - shamt+1 cycles for shifts.
- Shift details:
  - ASR replicates the MSB.
  - ROR feeds bit0 into the MSB and into C.
  - shamt max N-1, no wrap beyond.
- ADC/SBC use the C flag value at the accepting edge, which already includes the op just completed.
- Flags are visible from the DONE entry; they persist across ops until changed.
- Reset (async, any state, including mid-SHIFT): state=IDLE, result=0, alu_flags=4'b0000, out_valid=0, out_err=0, cnt=0. The in-flight op is discarded.

Optional Feature:
- ALU_MUL_EN defined: opcode 1110 = MUL, an unsigned iterative shift-add over N cycles in a MUL state; latency N+1.
  - result = low N bits of the product.
  - C = V = |(high N bits); N and Z from the low N bits.
  - in_ready=0 during MUL.
- ALU_MUL_EN undefined: 1110 is reserved (out_err=1, result 0, flags unchanged, 1-cycle latency); no MUL state or hardware.

Test Plan:
- N=8, ADD a=0x7F, b=0x01 -> out_valid one cycle after accept, result=0x80, alu_flags=4'b1100.
- SUB 0x05-0x05 -> result 0x00, flags 4'b0011; then ADC 0x10+0x20 -> result 0x31, flags 4'b0000.
- LSL a=0x81, b=3 -> in_ready=0 for 3 cycles, out_valid 4 cycles after accept, result 0x08, C=0. ROR 0x01 by 1 -> 0x80, flags 4'b0101. ASR 0x80 by 2 -> 0xE0, N=1.
- Hold out_ready=0 for 3 cycles after ADD 0x01+0x01 -> result 0x02 and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xFF^0x0F) -> accepted that edge, next result 0xF0, C/V preserved.
- reset_n low for one cycle in the middle of LSL by 7 -> out_valid=0, alu_flags=0, result=0 immediately (no clock edge needed). After release, in_ready=1 and the next ADD completes normally.
- Opcode 1111 -> out_err=1, result 0, flags unchanged. LSL by 0 with C=1 -> 1-cycle latency, result=a, C stays 1. With ALU_MUL_EN, MUL 0x10*0x10 -> result 0x00, Z=1, C=V=1, latency 9.
